// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between NUM_REQ writeback sources.
// The winning request is staged in a single output register; x0 destinations are consumed without a write.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16,
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          reg_write,
  output logic [ADDR_WIDTH-1:0]         write_reg,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [GW-1:0]                 grant_id,
  output logic [CNT_WIDTH-1:0]          conflict_cnt
);

  logic [GW-1:0]         rr_ptr;
  logic [ADDR_WIDTH-1:0] rd_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [GW:0]           scan_idx;
  logic [GW-1:0]         win_idx;
  logic                  found;
  logic                  fire;
  logic                  multi_valid;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign rd_arr[gi]   = req_rd[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Walk the requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (GW+1)'(k);
      if (scan_idx >= (GW+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (GW+1)'(NUM_REQ);
      end
      if (!found && req_valid[scan_idx[GW-1:0]]) begin
        found   = 1'b1;
        win_idx = scan_idx[GW-1:0];
      end
    end
  end

  assign fire        = found && !reset;
  assign req_ready   = fire ? (NUM_REQ'(1) << win_idx) : '0;
  // More than one bit set iff clearing the lowest set bit leaves something behind.
  assign multi_valid = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      reg_write    <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
      grant_id     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (fire) begin
        write_reg  <= rd_arr[win_idx];
        write_data <= data_arr[win_idx];
        grant_id   <= win_idx;
        reg_write  <= |rd_arr[win_idx];
        rr_ptr     <= (win_idx == GW'(NUM_REQ - 1)) ? '0 : win_idx + GW'(1);
      end else begin
        reg_write <= 1'b0;
      end
      if (multi_valid && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a per-requester request model drives stimulus,
// an abstract round-robin model queues expected outputs, and a monitor compares after each edge.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_rd;
  logic [N*DW-1:0] req_data;
  logic            reg_write;
  logic [AW-1:0]   write_reg;
  logic [DW-1:0]   write_data;
  logic [1:0]      grant_id;
  logic [CW-1:0]   conflict_cnt;

  regfile_wb_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .grant_id(grant_id), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [1:0]    gid;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Requesters: each holds its request until the model says it was granted.
  logic [N-1:0]  pend;
  logic [AW-1:0] prd  [N];
  logic [DW-1:0] pdat [N];

  // Abstract reference state.
  int            m_ptr;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  int            m_gid;
  int            m_cnt;

  // Register file as seen by the write port; a write is blocked by a coincident reset.
  logic [DW-1:0] rf [32];
  logic [DW-1:0] rf4_before;

  always @(posedge clk) begin
    if (reg_write && !reset) rf[write_reg] = write_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, expv);
    end
  endtask

  task automatic arm(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    pend[i] = 1'b1;
    prd[i]  = rd;
    pdat[i] = data;
  endtask

  task automatic tick(input logic rst);
    int   winner;
    int   idx;
    exp_t e;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    reset = rst;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pend[i];
      req_rd[i*AW +: AW]   = prd[i];
      req_data[i*DW +: DW] = pdat[i];
    end
    #1;
    winner = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (winner < 0 && pend[idx]) winner = idx;
      end
    end
    exp_ready = (winner >= 0) ? N'(1 << winner) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    e.we = 1'b0;
    if (rst) begin
      m_ptr = 0; m_rd = '0; m_data = '0; m_gid = 0; m_cnt = 0;
    end else begin
      if ($countones(pend) >= 2 && m_cnt < 15) m_cnt++;
      if (winner >= 0) begin
        e.we   = (prd[winner] != '0);
        m_rd   = prd[winner];
        m_data = pdat[winner];
        m_gid  = winner;
        m_ptr  = (winner + 1) % N;
        pend[winner] = 1'b0;
      end
    end
    e.rd = m_rd; e.data = m_data; e.gid = 2'(m_gid); e.cnt = CW'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (pend != '0 && n < 20) begin
      tick(1'b0);
      n++;
    end
    chk("drain_done", 64'(pend), 64'(0));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1)
          arm(i, AW'($urandom_range(31, 0)), {$urandom, $urandom});
      end
      tick(1'b0);
    end
  endtask

  // Monitor: one expected output record per clock edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_reg_write",    64'(reg_write),    64'(e.we));
        chk("sb_write_reg",    64'(write_reg),    64'(e.rd));
        chk("sb_write_data",   write_data,        e.data);
        chk("sb_grant_id",     64'(grant_id),     64'(e.gid));
        chk("sb_conflict_cnt", 64'(conflict_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t act=timeout exp=finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int r = 0; r < 32; r++) rf[r] = '0;
    reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    pend = '0;
    m_ptr = 0; m_rd = '0; m_data = '0; m_gid = 0; m_cnt = 0;
    for (int i = 0; i < N; i++) arm(i, AW'(i + 1), 64'(256 * (i + 1)));

    // Reset held with every requester valid.
    tick(1'b1);
    tick(1'b1);
    after_edge();
    chk("reset_reg_write", 64'(reg_write), 64'(0));
    chk("reset_conflict", 64'(conflict_cnt), 64'(0));

    // Continuous round-robin across all requesters.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) arm(i, AW'(i + 1), {$urandom, $urandom});
      tick(1'b0);
      after_edge();
      chk("rr_grant_id", 64'(grant_id), 64'(c % 3));
    end
    chk("rr_conflict6", 64'(conflict_cnt), 64'(6));
    drain();

    // Single requester.
    arm(1, 5'd5, 64'hDEAD_BEEF);
    tick(1'b0);
    after_edge();
    chk("single_reg_write", 64'(reg_write), 64'(1));
    chk("single_write_reg", 64'(write_reg), 64'(5));
    chk("single_write_data", write_data, 64'hDEAD_BEEF);
    chk("single_grant_id", 64'(grant_id), 64'(1));
    tick(1'b0);
    after_edge();
    chk("single_idle", 64'(reg_write), 64'(0));

    // x0 request consumed without a write, then a real write from the same source.
    arm(0, 5'd0, 64'h1234);
    tick(1'b0);
    after_edge();
    chk("x0_reg_write", 64'(reg_write), 64'(0));
    chk("x0_grant_id", 64'(grant_id), 64'(0));
    arm(0, 5'd7, 64'h77);
    tick(1'b0);
    after_edge();
    chk("x7_reg_write", 64'(reg_write), 64'(1));
    chk("x7_write_reg", 64'(write_reg), 64'(7));

    // Move the pointer to 2, then collide on x9.
    arm(1, 5'd0, 64'h0);
    tick(1'b0);
    arm(0, 5'd9, 64'hA);
    arm(2, 5'd9, 64'hB);
    tick(1'b0);
    after_edge();
    chk("coll_first", write_data, 64'hB);
    tick(1'b0);
    after_edge();
    chk("coll_second", write_data, 64'hA);
    tick(1'b0);
    tick(1'b0);
    after_edge();
    chk("coll_x9_final", rf[9], 64'hA);

    // Random traffic; the 4-bit counter must end saturated.
    random_phase(300);
    drain();
    after_edge();
    chk("cnt_saturated", 64'(conflict_cnt), 64'(15));

    // Reset while a write to x4 is staged.
    rf4_before = rf[4];
    arm(1, 5'd4, 64'h44);
    tick(1'b0);
    tick(1'b1);
    after_edge();
    chk("midreset_reg_write", 64'(reg_write), 64'(0));
    tick(1'b0);
    after_edge();
    chk("midreset_x4", rf[4], rf4_before);

    random_phase(50);
    drain();
    tick(1'b0);
    after_edge();
    #2;
    chk("sb_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
